// File: rtl/arm_pkg.sv
// Shared ALU/flag definitions for the condition path: operation encoding,
// NZCV bit positions and FlagW bit positions.
package arm_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        ORR = 2'b11
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational ALU: ADD/SUB share one WIDTH-bit adder (SUB = A + ~B + 1),
// AND/ORR are bitwise. Produces the result and its NZCV flags.
module alu_flags
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    alu_op_t          op;
    logic             sub;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic             carry;
    logic             ovf;

    assign op = alu_op_t'(ALUControl);

    always_comb begin
        sub  = (op == SUB);
        b_in = sub ? ~SrcB : SrcB;
        sum  = {1'b0, SrcA} + {1'b0, b_in} + {{WIDTH{1'b0}}, sub};
        // Overflow: both adder inputs agree in sign, the sum does not.
        add_ovf = (SrcA[WIDTH-1] == b_in[WIDTH-1]) &&
                  (sum[WIDTH-1] != SrcA[WIDTH-1]);
    end

    always_comb begin
        Result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (op)
            ADD, SUB: begin
                Result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = add_ovf;
            end
            AND: Result = SrcA & SrcB;
            ORR: Result = SrcA | SrcB;
            default: Result = '0;
        endcase
    end

    assign ALUFlags = pack_nzcv(Result[WIDTH-1], (Result == '0), carry, ovf);

endmodule

// File: rtl/flag_unit.sv
// Architectural NZCV flag register: two independently enabled pairs (NZ, CV)
// fed from the ALU, qualified by CondEx and blocked by Stall/Flush.
module flag_unit
    import arm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       ALUControl,
    input  logic [1:0]       FlagW,
    input  logic             CondEx,
    input  logic             Stall,
    input  logic             Flush,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       Flags
);

    logic       issue_ok;
    logic       we_nz;
    logic       we_cv;
    logic [1:0] alu_nz;
    logic [1:0] alu_cv;
    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic [1:0] nz_out;
    logic [1:0] cv_out;

    alu_flags #(
        .WIDTH(WIDTH)
    ) u_alu_flags (
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUControl(ALUControl),
        .Result    (Result),
        .ALUFlags  (ALUFlags)
    );

    assign issue_ok = CondEx & ~Stall & ~Flush;
    assign we_nz    = FlagW[FLAGW_NZ] & issue_ok;
    assign we_cv    = FlagW[FLAGW_CV] & issue_ok;

    assign alu_nz = {ALUFlags[FLAG_N], ALUFlags[FLAG_Z]};
    assign alu_cv = {ALUFlags[FLAG_C], ALUFlags[FLAG_V]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nz_q <= 2'b00;
        end else if (we_nz) begin
            nz_q <= alu_nz;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cv_q <= 2'b00;
        end else if (we_cv) begin
            cv_q <= alu_cv;
        end
    end

    // The forwarding path is gated by reset_n so Flags reads zero for the
    // whole reset interval, even while a write request is being presented.
    generate
        if (BYPASS) begin : g_bypass
            assign nz_out = (we_nz & reset_n) ? alu_nz : nz_q;
            assign cv_out = (we_cv & reset_n) ? alu_cv : cv_q;
        end else begin : g_no_bypass
            assign nz_out = nz_q;
            assign cv_out = cv_q;
        end
    endgenerate

    assign Flags = pack_nzcv(nz_out[1], nz_out[0], cv_out[1], cv_out[0]);

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: BYPASS=0 and BYPASS=1 instances on shared stimulus,
// directed table rows plus randomized cycles against an arithmetic model.
module tb_flag_unit;

    localparam int W = 32;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  srca, srcb;
    logic [1:0]    aluctl, flagw;
    logic          condex, stall, flush;
    logic [W-1:0]  result0, result1;
    logic [3:0]    aluflags0, aluflags1, flags0, flags1;

    int checks = 0;
    int errors = 0;

    flag_unit #(.WIDTH(W), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .SrcA(srca), .SrcB(srcb),
        .ALUControl(aluctl), .FlagW(flagw), .CondEx(condex), .Stall(stall),
        .Flush(flush), .Result(result0), .ALUFlags(aluflags0), .Flags(flags0)
    );

    flag_unit #(.WIDTH(W), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .SrcA(srca), .SrcB(srcb),
        .ALUControl(aluctl), .FlagW(flagw), .CondEx(condex), .Stall(stall),
        .Flush(flush), .Result(result1), .ALUFlags(aluflags1), .Flags(flags1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  fw;
        logic        ce;
        logic        st;
        logic        fl;
        logic [31:0] res;
        logic [3:0]  alu;
        logic [3:0]  after;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_row(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fw, input logic ce, input logic st, input logic fl,
                           input logic [31:0] res, input logic [3:0] alu, input logic [3:0] after);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.fw = fw; v.ce = ce; v.st = st; v.fl = fl;
        v.res = res; v.alu = alu; v.after = after;
        tbl.push_back(v);
    endtask

    // Reference ALU from plain integer arithmetic on 64-bit values.
    function automatic void ref_alu(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [3:0] f);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint full;
        longint sfull;
        logic   c;
        logic   v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            2'b00: begin
                full  = ua + ub;
                sfull = sa + sb;
                r = full[31:0];
                c = (full > 64'sd4294967295);
                v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            2'b01: begin
                full  = ua - ub;
                sfull = sa - sb;
                r = full[31:0];
                c = (ua >= ub);
                v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    logic [3:0]  model_reg;
    logic [3:0]  prev;
    logic [31:0] exp_r;
    logic [3:0]  exp_f;
    logic [3:0]  exp_byp;
    logic        m_we_nz, m_we_cv;

    initial begin
        reset_n = 1'b0;
        srca = 32'd5; srcb = 32'd5; aluctl = 2'b01;
        flagw = 2'b11; condex = 1'b1; stall = 1'b0; flush = 1'b0;

        #1;
        chk("reset_flags0_t0", {28'd0, flags0}, 32'd0);
        chk("reset_flags1_t0", {28'd0, flags1}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_flags0_lo", {28'd0, flags0}, 32'd0);
            chk("reset_flags1_lo", {28'd0, flags1}, 32'd0);
            @(posedge clk); #1;
            chk("reset_flags0_hi", {28'd0, flags0}, 32'd0);
            chk("reset_flags1_hi", {28'd0, flags1}, 32'd0);
        end
        flagw = 2'b00;
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_reset_flags0", {28'd0, flags0}, 32'd0);
            chk("post_reset_flags1", {28'd0, flags1}, 32'd0);
        end

        add_row(2'b01, 32'd5,         32'd5,         2'b11, 1, 0, 0, 32'h0000_0000, 4'b0110, 4'b0110);
        add_row(2'b00, 32'h7FFF_FFFF, 32'h1,         2'b11, 1, 0, 0, 32'h8000_0000, 4'b1001, 4'b1001);
        add_row(2'b00, 32'hFFFF_FFFF, 32'h1,         2'b11, 1, 0, 0, 32'h0000_0000, 4'b0110, 4'b0110);
        add_row(2'b00, 32'h7FFF_FFFF, 32'h1,         2'b11, 1, 0, 0, 32'h8000_0000, 4'b1001, 4'b1001);
        add_row(2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 1, 0, 0, 32'h0000_0000, 4'b0100, 4'b0101);
        add_row(2'b01, 32'd3,         32'd5,         2'b11, 0, 0, 0, 32'hFFFF_FFFE, 4'b1000, 4'b0101);
        add_row(2'b01, 32'd3,         32'd5,         2'b11, 1, 1, 0, 32'hFFFF_FFFE, 4'b1000, 4'b0101);
        add_row(2'b01, 32'd3,         32'd5,         2'b11, 1, 0, 1, 32'hFFFF_FFFE, 4'b1000, 4'b0101);
        add_row(2'b01, 32'd3,         32'd5,         2'b11, 1, 1, 1, 32'hFFFF_FFFE, 4'b1000, 4'b0101);
        add_row(2'b01, 32'd3,         32'd5,         2'b11, 1, 0, 0, 32'hFFFF_FFFE, 4'b1000, 4'b1000);
        add_row(2'b11, 32'h0,         32'h0,         2'b01, 1, 0, 0, 32'h0000_0000, 4'b0100, 4'b1000);
        add_row(2'b01, 32'h8000_0000, 32'h1,         2'b11, 1, 0, 0, 32'h7FFF_FFFF, 4'b0011, 4'b0011);
        add_row(2'b11, 32'h8000_0000, 32'h1,         2'b10, 1, 0, 0, 32'h8000_0001, 4'b1000, 4'b1011);
        add_row(2'b10, 32'hFFFF_FFFF, 32'h0,         2'b01, 1, 0, 0, 32'h0000_0000, 4'b0100, 4'b1000);

        prev = 4'b0000;
        for (int i = 0; i < tbl.size(); i++) begin
            aluctl = tbl[i].op; srca = tbl[i].a; srcb = tbl[i].b;
            flagw = tbl[i].fw; condex = tbl[i].ce; stall = tbl[i].st; flush = tbl[i].fl;
            #3;
            chk($sformatf("row%0d_result", i), result0, tbl[i].res);
            chk($sformatf("row%0d_aluflags", i), {28'd0, aluflags0}, {28'd0, tbl[i].alu});
            chk($sformatf("row%0d_flags0_pre", i), {28'd0, flags0}, {28'd0, prev});
            chk($sformatf("row%0d_flags1_bypass", i), {28'd0, flags1}, {28'd0, tbl[i].after});
            @(posedge clk); #1;
            chk($sformatf("row%0d_flags0_post", i), {28'd0, flags0}, {28'd0, tbl[i].after});
            prev = tbl[i].after;
        end
        model_reg = prev;

        for (int i = 0; i < 300; i++) begin
            aluctl = 2'($urandom_range(0, 3));
            srca   = pick_operand();
            srcb   = pick_operand();
            flagw  = 2'($urandom_range(0, 3));
            condex = ($urandom_range(0, 3) != 0);
            stall  = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 4) == 0);
            ref_alu(aluctl, srca, srcb, exp_r, exp_f);
            m_we_nz = flagw[1] && condex && !stall && !flush;
            m_we_cv = flagw[0] && condex && !stall && !flush;
            exp_byp = {m_we_nz ? exp_f[3:2] : model_reg[3:2],
                       m_we_cv ? exp_f[1:0] : model_reg[1:0]};
            #3;
            chk("rand_result0", result0, exp_r);
            chk("rand_result1", result1, exp_r);
            chk("rand_aluflags", {28'd0, aluflags0}, {28'd0, exp_f});
            chk("rand_flags0", {28'd0, flags0}, {28'd0, model_reg});
            chk("rand_flags1", {28'd0, flags1}, {28'd0, exp_byp});
            @(posedge clk); #1;
            model_reg = exp_byp;
        end
        #3;
        chk("rand_flags0_final", {28'd0, flags0}, {28'd0, model_reg});

        aluctl = 2'b01; srca = 32'd3; srcb = 32'd5;
        flagw = 2'b11; condex = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("preload_flags0", {28'd0, flags0}, 32'h8);
        aluctl = 2'b00; srca = 32'hFFFF_FFFF; srcb = 32'h1;
        #2;
        chk("preload_flags1_bypass", {28'd0, flags1}, 32'h6);
        reset_n = 1'b0;
        #1;
        chk("midreset_flags0", {28'd0, flags0}, 32'd0);
        chk("midreset_flags1", {28'd0, flags1}, 32'd0);
        @(posedge clk); #1;
        chk("midreset_flags0_edge", {28'd0, flags0}, 32'd0);
        chk("midreset_flags1_edge", {28'd0, flags1}, 32'd0);
        flagw = 2'b00;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_release0", {28'd0, flags0}, 32'd0);
        chk("midreset_release1", {28'd0, flags1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Flag-producing end of the condition path. It computes NZCV from the current ALU operation and holds the architectural flags in a register. It commits new flags only when the instruction is allowed to write them and actually executes. It drives `Flags` into the condition checker, and `CondEx` comes back from that checker to qualify the write.

## Interface
Parameters:
- `WIDTH`, 32, datapath width in bits.
- `BYPASS`, 0. When 1, `Flags` forwards the value being written in the same cycle. When 0, `Flags` is purely the register output.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `SrcA`  in  WIDTH  first ALU operand.
- `SrcB`  in  WIDTH  second ALU operand.
- `ALUControl`  in  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `FlagW`  in  2  flag write request. Bit 1 covers N,Z; bit 0 covers C,V.
- `CondEx`  in  1  instruction passes its condition.
- `Stall`  in  1  hold; blocks any flag write.
- `Flush`  in  1  squash; blocks any flag write.
- `Result`  out  WIDTH  combinational ALU result.
- `ALUFlags`  out  4  combinational NZCV of the current operation.
- `Flags`  out  4  architectural flags {N,Z,C,V}, with N at bit 3.

## Operation
- ADD: `Result` = SrcA+SrcB. SUB: `Result` = SrcA+~SrcB+1. AND and ORR are bitwise. All results are truncated to WIDTH.
- N = Result[WIDTH-1]. Z = (Result == 0).
- C = carry-out of the WIDTH-bit adder for ADD/SUB. For SUB, C=1 means no borrow. C = 0 for AND/ORR.
- V is set for ADD/SUB only, when both adder inputs share a sign that differs from the result sign. The adder inputs are SrcA and SrcB for ADD, SrcA and ~SrcB for SUB. V = 0 for AND/ORR.
- Write enables:
  - `weNZ` = FlagW[1] & CondEx & ~Stall & ~Flush.
  - `weCV` = FlagW[0] & CondEx & ~Stall & ~Flush.
- The NZ pair and the CV pair are independent registers. A pair not enabled holds its value.
- `Flags` output:
  - BYPASS=0: the register contents.
  - BYPASS=1: each pair shows the incoming `ALUFlags` value while its enable is high, otherwise the register contents.

## Timing
- Reset: while reset_n=0, Flags = 4'b0000 immediately, independent of clk. Registers stay 0 until the first rising edge after reset_n rises.
- `Result` and `ALUFlags` depend only on the current inputs: combinational, zero cycles.
- Write latency with BYPASS=0: the edge that samples the enable updates the register, and `Flags` shows the new value in the following cycle.
- Write latency with BYPASS=1: the new value is visible in the write cycle itself and is held after the edge.
- Stall or Flush on the sampling edge:
  - No write happens, whatever FlagW and CondEx are.
  - Stall and Flush high together also means no write.
- Back-to-back writes on consecutive cycles are each committed. The last enabled write to a pair wins.
- reset_n asserted mid-cycle clears both pairs at once. Any write in that cycle is lost.
- Unknown ALUControl cannot occur, because all four codes are defined.

## Structure
- Shared package `arm_pkg` holds:
  - the `alu_op_t` enum (ADD, SUB, AND, ORR);
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FlagW bit constants FLAGW_NZ=1, FLAGW_CV=0.
- The condition checker imports the same flag indices.
- Sub-module `alu_flags` is purely combinational. It produces `Result` and `ALUFlags` from SrcA, SrcB and ALUControl.
- The top level holds the two flag registers, the write-enable logic and the BYPASS mux.

## Test plan
1. Reset: hold reset_n=0 with toggling clk and FlagW=11, CondEx=1 -> Flags=0000 throughout. After release with FlagW=00, Flags stays 0000.
2. SUB 5-5, FlagW=11, CondEx=1 -> Result=0, ALUFlags=0110. Flags=0110 on the next cycle (BYPASS=0).
3. ADD 0x7FFFFFFF+0x00000001, FlagW=11 -> Result=0x80000000, Flags=1001. Then ADD 0xFFFFFFFF+1 -> Result=0, Flags=0110.
4. Prior flags 1001, then AND 0xF0F0F0F0 & 0x0F0F0F0F with FlagW=10 -> Z=1 and C,V preserved, giving Flags=0101.
5. SUB 3-5 with FlagW=11 and each of: CondEx=0, Stall=1, Flush=1 -> Flags unchanged every time. With all three deasserted -> Flags=1000.
6. BYPASS=1: SUB 5-5 with FlagW=11 -> Flags=0110 combinationally in the write cycle and held afterwards. Drop reset_n between clock edges -> Flags=0000 without waiting for an edge.
